// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-game pattern datapath.
package mem_pkg;

    localparam int PATTERN_W = 16;

    // Feedback taps of x^16+x^14+x^13+x^11+1 in a right-shifting Fibonacci register.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXTEND,
        ST_SHOW,
        ST_GAP,
        ST_DONE,
        ST_HOLD
    } player_state_t;

    // One LFSR step: shift right, feedback enters at the MSB.
    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {^(q & LFSR_TAPS), q[15:1]};
    endfunction

endpackage

// File: rtl/pattern_player_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; only reset reloads the seed.
module lfsr16
    import mem_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    // Advance every cycle so each game draws a different bit sequence.
    always_ff @(posedge clk) begin
        if (rst) q <= SEED;
        else     q <= lfsr_step(q);
    end

endmodule

// File: rtl/pattern_player.sv
// Grows the secret pattern by one random bit per round and plays it on the LED,
// oldest bit first, with a fixed on-time and blank gap per bit.
module pattern_player
    import mem_pkg::*;
#(
    parameter int          MAX_LEN    = 16,
    parameter int          ON_CYCLES  = 4,
    parameter int          GAP_CYCLES = 2,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        gen_pattern,
    output logic        done_gen_pattern,
    output logic        led_valid,
    output logic        led_bit,
    output logic [15:0] game_pattern,
    output logic [15:0] count,
    output logic        full,
    output logic        busy
);

    localparam int              DWELL_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int              DW        = $clog2(DWELL_MAX + 1);
    localparam logic [DW-1:0]   ON_LOAD   = DW'(ON_CYCLES - 1);
    localparam logic [DW-1:0]   GAP_LOAD  = DW'(GAP_CYCLES - 1);
    localparam logic [4:0]      MAX_CNT   = 5'(MAX_LEN);

    player_state_t          state_q, state_d;
    logic [4:0]             cnt_q;
    logic [4:0]             cnt_new;
    logic                   can_grow;
    logic [PATTERN_W-1:0]   pat_q;
    logic [3:0]             idx_q;
    logic [DW-1:0]          dwell_q;
    logic [15:0]            lfsr_q;
    logic [14:0]            lfsr_unused;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    // Upper LFSR bits only feed the shift chain; the new pattern bit is q[0].
    assign lfsr_unused = lfsr_q[15:1];

    // Once full, a round replays the existing pattern instead of growing it.
    assign can_grow = (cnt_q < MAX_CNT);
    assign cnt_new  = can_grow ? cnt_q + 5'd1 : cnt_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and LED/done decode; clr abandons the round from any state.
    always_comb begin
        state_d          = state_q;
        led_valid        = 1'b0;
        done_gen_pattern = 1'b0;
        unique case (state_q)
            ST_IDLE:   if (gen_pattern) state_d = ST_EXTEND;
            ST_EXTEND: state_d = ST_SHOW;
            ST_SHOW: begin
                led_valid = 1'b1;
                if (dwell_q == '0) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (dwell_q == '0) state_d = (idx_q == 4'd0) ? ST_DONE : ST_SHOW;
            end
            ST_DONE: begin
                done_gen_pattern = 1'b1;
                state_d          = ST_HOLD;
            end
            ST_HOLD:   if (!gen_pattern) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (clr) state_d = ST_IDLE;
    end

    // Pattern, length, bit index and dwell timer; dwell reloads on each SHOW/GAP entry.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q   <= '0;
            pat_q   <= '0;
            idx_q   <= '0;
            dwell_q <= '0;
        end else begin
            unique case (state_q)
                ST_EXTEND: begin
                    if (can_grow) begin
                        pat_q <= {pat_q[PATTERN_W-2:0], lfsr_q[0]};
                        cnt_q <= cnt_new;
                    end
                    idx_q   <= 4'(cnt_new - 5'd1);
                    dwell_q <= ON_LOAD;
                end
                ST_SHOW: begin
                    if (dwell_q == '0) dwell_q <= GAP_LOAD;
                    else               dwell_q <= dwell_q - DW'(1);
                end
                ST_GAP: begin
                    if (dwell_q == '0) begin
                        dwell_q <= ON_LOAD;
                        if (idx_q != 4'd0) idx_q <= idx_q - 4'd1;
                    end else begin
                        dwell_q <= dwell_q - DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign led_bit      = led_valid & pat_q[idx_q];
    assign game_pattern = pat_q;
    assign count        = {11'b0, cnt_q};
    assign full         = (cnt_q == MAX_CNT);
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pattern_player.sv
// Randomized scoreboard bench for pattern_player.
module tb_pattern_player;

    localparam int MAX_LEN = 16;
    localparam int ON      = 4;
    localparam int GAP     = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        gen = 1'b0;
    logic        done_gen_pattern;
    logic        led_valid;
    logic        led_bit;
    logic [15:0] game_pattern;
    logic [15:0] count;
    logic        full;
    logic        busy;

    always #5 clk = ~clk;

    pattern_player #(
        .MAX_LEN    (MAX_LEN),
        .ON_CYCLES  (ON),
        .GAP_CYCLES (GAP),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .clr              (clr),
        .gen_pattern      (gen),
        .done_gen_pattern (done_gen_pattern),
        .led_valid        (led_valid),
        .led_bit          (led_bit),
        .game_pattern     (game_pattern),
        .count            (count),
        .full             (full),
        .busy             (busy)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          bits_seen = 0;
    bit          abort = 1'b0;
    logic [15:0] ref_lfsr;

    bit          model_bits[$];   // secret pattern, oldest bit first
    bit          exp_bits[$];     // bits the LED is expected to show, in order
    int          exp_done[$];     // cycle numbers at which done must be seen

    bit          mon_prev = 1'b0;
    int          mon_run = 0;
    bit          mon_b;
    int          mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference random source: x^16+x^14+x^13+x^11+1, new bit leaves at bit 0.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) ref_lfsr <= 16'hACE1;
        else     ref_lfsr <= {ref_lfsr[0] ^ ref_lfsr[2] ^ ref_lfsr[3] ^ ref_lfsr[5], ref_lfsr[15:1]};
    end

    function automatic logic [15:0] model_gp();
        logic [15:0] gp = '0;
        int n = model_bits.size();
        for (int i = 0; i < n; i++) gp[n-1-i] = model_bits[i];
        return gp;
    endfunction

    // Monitor: pops expectations whenever the DUT shows a bit or pulses done.
    initial begin
        forever begin
            @(negedge clk);
            if (led_valid && !mon_prev) begin
                bits_seen++;
                mon_run = 1;
                if (exp_bits.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_bit: got led_valid=1 expected no bit (cycle %0d)", cyc);
                end else begin
                    mon_b = exp_bits.pop_front();
                    chk("led_bit", 32'(led_bit), 32'(mon_b));
                end
            end else if (led_valid) begin
                mon_run++;
            end
            if (!led_valid && mon_prev && !abort) chk("on_len", 32'(mon_run), 32'(ON));
            if (!led_valid && led_bit) chk("led_bit_blank", 32'(led_bit), 32'd0);
            if (done_gen_pattern) begin
                done_cnt++;
                if (exp_done.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    mon_e = exp_done.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(mon_e));
                end
            end
            mon_prev = led_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin tick(); n++; end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic start_round(output int dc);
        wait_idle();
        dc  = done_cnt;
        gen = 1'b1;
        tick();   // DUT is now in its extend cycle; ref_lfsr matches its LFSR
        chk("busy_extend", 32'(busy), 32'd1);
        if (model_bits.size() < MAX_LEN) model_bits.push_back(ref_lfsr[0]);
        foreach (model_bits[i]) exp_bits.push_back(model_bits[i]);
        exp_done.push_back(cyc + 1 + model_bits.size() * (ON + GAP));
    endtask

    task automatic check_pattern();
        chk("count", 32'(count), 32'(model_bits.size()));
        chk("full", 32'(full), 32'(model_bits.size() == MAX_LEN));
        chk("game_pattern", 32'(game_pattern), 32'(model_gp()));
    endtask

    task automatic run_round(input int drop_after, input int hold_extra);
        int dc;
        int n = 0;
        int d0;
        start_round(dc);
        while (done_cnt == dc && n < 300) begin
            if (n == drop_after) gen = 1'b0;
            tick();
            n++;
        end
        chk("done_seen", 32'(done_cnt - dc), 32'd1);
        d0 = done_cnt;
        if (gen) begin
            for (int i = 0; i < hold_extra; i++) begin
                chk("hold_busy", 32'(busy), 32'd1);
                tick();
            end
            chk("hold_no_replay", 32'(done_cnt), 32'(d0));
        end
        gen = 1'b0;
        tick();
        tick();
        chk("idle_after", 32'(busy), 32'd0);
        check_pattern();
    endtask

    task automatic flush_model();
        exp_bits.delete();
        exp_done.delete();
        model_bits.delete();
    endtask

    task automatic run_clr_round();
        int dc;
        int bs = bits_seen;
        int n = 0;
        start_round(dc);
        while (bits_seen < bs + 3 && n < 300) begin tick(); n++; end
        chk("third_bit_seen", 32'(bits_seen - bs), 32'd3);
        clr = 1'b1;
        tick();
        clr   = 1'b0;
        gen   = 1'b0;
        abort = 1'b1;
        flush_model();
        chk("clr_led_valid", 32'(led_valid), 32'd0);
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_pattern", 32'(game_pattern), 32'd0);
        repeat (20) tick();
        abort = 1'b0;
        chk("clr_no_done", 32'(done_cnt), 32'(dc));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish by 50000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_pattern", 32'(game_pattern), 32'd0);
        chk("rst_led", 32'({led_valid, led_bit, done_gen_pattern, full}), 32'd0);
        chk("rst_lfsr", 32'(dut.u_lfsr.q), 32'hACE1);
        rst = 1'b0;
        repeat (int'($urandom_range(0, 5))) tick();

        // first round with the request level held throughout, then three rounds total
        run_round(1000, 0);
        run_round(int'($urandom_range(0, 30)), 0);
        run_round(int'($urandom_range(0, 30)), 3);

        // clear while the third bit of a four-bit playback is showing
        run_clr_round();
        run_round(int'($urandom_range(0, 10)), 0);

        // grow to full length and replay twice more
        for (int r = 0; r < 17; r++) begin
            run_round(int'($urandom_range(0, 120)), int'($urandom_range(0, 4)));
            repeat (int'($urandom_range(0, 3))) tick();
        end

        // request held well past done: no second round
        run_round(1000, 10);

        // clr and gen_pattern together in idle
        wait_idle();
        gen = 1'b1;
        clr = 1'b1;
        tick();
        flush_model();
        chk("clrgen_busy", 32'(busy), 32'd0);
        chk("clrgen_count", 32'(count), 32'd0);
        gen = 1'b0;
        clr = 1'b0;
        repeat (3) tick();
        chk("clrgen_idle", 32'(busy), 32'd0);

        // rst together with clr in the middle of a playback
        run_round(0, 0);
        run_round(0, 0);
        begin
            int dc;
            start_round(dc);
            repeat (8) tick();
            rst   = 1'b1;
            clr   = 1'b1;
            abort = 1'b1;
            tick();
            flush_model();
            gen = 1'b0;
            chk("rst_mid_lfsr", 32'(dut.u_lfsr.q), 32'hACE1);
            chk("rst_mid_busy", 32'(busy), 32'd0);
            chk("rst_mid_count", 32'(count), 32'd0);
            chk("rst_mid_led", 32'(led_valid), 32'd0);
            rst = 1'b0;
            clr = 1'b0;
            repeat (10) tick();
            abort = 1'b0;
            chk("rst_mid_no_done", 32'(done_cnt), 32'(dc));
        end
        run_round(1000, 2);

        repeat (5) tick();
        chk("queues_drained", 32'(exp_bits.size() + exp_done.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
